// File: rtl/ifu.sv
// Instruction fetch unit: one AXI-lite read at a time from the fetch PC,
// hands the word to decode, and follows redirects (flushing any in-flight read).
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned XLEN      = 32;
  localparam int unsigned INST_BYTES = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [XLEN-1:0]   pc, pc_nxt;
  logic              flush_pending, flush_pending_nxt;
  logic [XLEN-1:0]   flush_pc, flush_pc_nxt;
  logic              capture_c;

  // Next-state, next-PC and flush bookkeeping
  always_comb begin
    state_nxt         = state;
    pc_nxt            = pc;
    flush_pending_nxt = flush_pending;
    flush_pc_nxt      = flush_pc;
    capture_c         = 1'b0;
    case (state)
      S_IDLE: begin
        state_nxt = S_AR;
        if (redirect_valid) pc_nxt = redirect_pc;
      end
      S_AR: begin
        // araddr must stay stable while arvalid is up, so the target is parked
        if (redirect_valid) begin
          flush_pending_nxt = 1'b1;
          flush_pc_nxt      = redirect_pc;
        end
        if (arvalid && arready) state_nxt = S_R;
      end
      S_R: begin
        if (redirect_valid) begin
          flush_pending_nxt = 1'b1;
          flush_pc_nxt      = redirect_pc;
        end
        if (rvalid) begin
          if (redirect_valid) begin
            pc_nxt            = redirect_pc;
            flush_pending_nxt = 1'b0;
            state_nxt         = S_AR;
          end else if (flush_pending) begin
            pc_nxt            = flush_pc;
            flush_pending_nxt = 1'b0;
            state_nxt         = S_AR;
          end else begin
            capture_c = 1'b1;
            state_nxt = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (redirect_valid) begin
          pc_nxt    = redirect_pc;
          state_nxt = S_AR;
        end else if (inst_ready) begin
          pc_nxt    = pc + XLEN'(INST_BYTES);
          state_nxt = S_AR;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, PC and flush registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      pc            <= RESET_PC;
      flush_pending <= 1'b0;
      flush_pc      <= '0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      flush_pending <= flush_pending_nxt;
      flush_pc      <= flush_pc_nxt;
    end
  end

  // Registered handshake outputs, decoded from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      inst_valid <= 1'b0;
      araddr     <= RESET_PC;
    end else begin
      arvalid    <= (state_nxt == S_AR);
      rready     <= (state_nxt == S_R);
      inst_valid <= (state_nxt == S_OUT);
      araddr     <= pc_nxt;
    end
  end

  // Instruction payload, loaded only for responses that will be delivered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst     <= '0;
      inst_pc  <= '0;
      inst_err <= 1'b0;
    end else if (capture_c) begin
      inst     <= rdata;
      inst_pc  <= pc;
      inst_err <= rresp;
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: the bench plays the memory slave and decode stage.
module tb_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_errors = 0;
  int n_accept = 0;
  int n_both   = 0;

  ifu #(.RESET_PC(32'h8000_0000)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst(inst), .inst_pc(inst_pc), .inst_err(inst_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // Decode-side acceptance count and AXI exclusivity monitor
  always @(posedge clk) begin
    if (rst && inst_valid && inst_ready) n_accept++;
    if (arvalid && rready) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; arready = 1'b1; rdata = '0; rresp = 1'b0; rvalid = 1'b0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    step(); step();

    // Reset values
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_rready", 32'(rready), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_inst_err", 32'(inst_err), 32'd0);

    // Release: IDLE on the first edge, AR after it
    rst = 1'b1;
    check("idle_arvalid", 32'(arvalid), 32'd0);
    step();
    check("first_arvalid", 32'(arvalid), 32'd1);
    check("first_araddr", araddr, 32'h8000_0000);
    step();
    check("r_rready", 32'(rready), 32'd1);
    check("r_arvalid", 32'(arvalid), 32'd0);
    rvalid = 1'b1; rdata = 32'h0000_0413;
    step();
    rvalid = 1'b0; arready = 1'b0;
    check("out_valid", 32'(inst_valid), 32'd1);
    check("out_inst", inst, 32'h0000_0413);
    check("out_pc", inst_pc, 32'h8000_0000);
    check("out_err", 32'(inst_err), 32'd0);

    // Decode stall: payload holds, no new read
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", 32'(inst_valid), 32'd1);
      check("stall_inst", inst, 32'h0000_0413);
      check("stall_pc", inst_pc, 32'h8000_0000);
      check("stall_arvalid", 32'(arvalid), 32'd0);
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    check("next_araddr", araddr, 32'h8000_0004);
    check("next_arvalid", 32'(arvalid), 32'd1);
    check("next_inst_valid", 32'(inst_valid), 32'd0);

    // arready low for three cycles
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_arvalid", 32'(arvalid), 32'd1);
      check("wait_araddr", araddr, 32'h8000_0004);
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    check("hs_arvalid", 32'(arvalid), 32'd0);
    check("hs_rready", 32'(rready), 32'd1);
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 1'b1;
    step();
    rvalid = 1'b0; rresp = 1'b0;
    check("err_valid", 32'(inst_valid), 32'd1);
    check("err_flag", 32'(inst_err), 32'd1);
    check("err_inst", inst, 32'hDEAD_BEEF);
    check("err_pc", inst_pc, 32'h8000_0004);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    check("after_err_araddr", araddr, 32'h8000_0008);

    // Redirect during R: response discarded
    arready = 1'b1;
    step();
    arready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    step();
    redirect_valid = 1'b0;
    check("flush_still_r", 32'(rready), 32'd1);
    rvalid = 1'b1; rdata = 32'h1111_1111;
    step();
    rvalid = 1'b0;
    check("flush_no_valid", 32'(inst_valid), 32'd0);
    check("flush_arvalid", 32'(arvalid), 32'd1);
    check("flush_araddr", araddr, 32'h8000_0100);

    // Redirect in OUT coincident with inst_ready
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h2222_2222;
    step();
    rvalid = 1'b0;
    check("redir_out_inst", inst, 32'h2222_2222);
    check("redir_out_pc", inst_pc, 32'h8000_0100);
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    step();
    inst_ready = 1'b0; redirect_valid = 1'b0;
    check("redir_out_araddr", araddr, 32'h8000_0200);
    check("redir_out_valid", 32'(inst_valid), 32'd0);
    check("accept_count_a", 32'(n_accept), 32'd3);

    // Redirect coincident with rvalid
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h2323_2323; redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
    step();
    rvalid = 1'b0; redirect_valid = 1'b0;
    check("coinc_valid", 32'(inst_valid), 32'd0);
    check("coinc_araddr", araddr, 32'h8000_0300);

    // Two redirects in AR: latest wins, araddr stable meanwhile; then PC wrap
    redirect_valid = 1'b1; redirect_pc = 32'h1234_5678;
    step();
    check("ar_redir_hold", araddr, 32'h8000_0300);
    redirect_pc = 32'hFFFF_FFFC; arready = 1'b1;
    step();
    redirect_valid = 1'b0; arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h5555_5555;
    step();
    rvalid = 1'b0;
    check("latest_wins", araddr, 32'hFFFF_FFFC);
    check("latest_no_valid", 32'(inst_valid), 32'd0);
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h0000_0033;
    step();
    rvalid = 1'b0;
    check("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    check("wrap_araddr", araddr, 32'h0000_0000);

    // Reset during R with rvalid arriving while in reset
    arready = 1'b1;
    step();
    arready = 1'b0;
    check("pre_rst_rready", 32'(rready), 32'd1);
    rst = 1'b0;
    #1;
    check("async_rready", 32'(rready), 32'd0);
    check("async_arvalid", 32'(arvalid), 32'd0);
    rvalid = 1'b1; rdata = 32'h7777_7777;
    step();
    check("inrst_valid", 32'(inst_valid), 32'd0);
    check("inrst_inst", inst, 32'd0);
    rst = 1'b1;
    step();
    check("post_rst_araddr", araddr, 32'h8000_0000);
    check("post_rst_arvalid", 32'(arvalid), 32'd1);
    step();
    check("stale_rvalid_ignored", 32'(inst_valid), 32'd0);
    check("stale_rready", 32'(rready), 32'd0);
    rvalid = 1'b0;
    step();
    check("accept_count_b", 32'(n_accept), 32'd4);
    check("ar_r_exclusive", 32'(n_both), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
